// File: rtl/fpu_issue_ctrl.sv
// Issue/sequencing stage in front of FP_Unit: latches one FP op, starts the unit, waits, captures result.
// Latency: ADD/SUB/MUL result valid FIX_LAT+1 cycles after accept; DIV waits for FP_Unit stall then DIV_SETTLE.
// Backpressure: one op in flight; out_ready only in IDLE, result held in RESULT until in_wb_ready.
// Ports: in_Clk/in_Rst (sync, active-high); execute side in_valid/in_rs1/in_rs2/in_FPU_Op/in_rd/in_flush,
//        out_ready/out_pipe_stall; FP_Unit side out_fpu_rs1/rs2/op/start, in_fpu_data/in_fpu_stall;
//        writeback side out_wb_valid/out_wb_rd/out_wb_data, in_wb_ready; out_err sticky DIV timeout.
module fpu_issue_ctrl #(
  parameter int FIX_LAT     = 2,
  parameter int DIV_SETTLE  = 2,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic        in_Clk,
  input  logic        in_Rst,
  input  logic        in_valid,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic [1:0]  in_FPU_Op,
  input  logic [4:0]  in_rd,
  input  logic        in_flush,
  output logic        out_ready,
  output logic        out_pipe_stall,
  output logic [31:0] out_fpu_rs1,
  output logic [31:0] out_fpu_rs2,
  output logic [1:0]  out_fpu_op,
  output logic        out_fpu_start,
  input  logic [31:0] in_fpu_data,
  input  logic        in_fpu_stall,
  output logic        out_wb_valid,
  output logic [4:0]  out_wb_rd,
  output logic [31:0] out_wb_data,
  input  logic        in_wb_ready,
  output logic        out_err
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ISSUE    = 3'd1;
  localparam logic [2:0] ST_WAIT_FIX = 3'd2;
  localparam logic [2:0] ST_WAIT_DIV = 3'd3;
  localparam logic [2:0] ST_SETTLE   = 3'd4;
  localparam logic [2:0] ST_RESULT   = 3'd5;
  localparam logic [2:0] ST_DRAIN    = 3'd6;

  localparam logic [1:0] OP_DIV = 2'b11;

  // One shared counter covers fixed latency, DIV timeout and settle delay.
  localparam int CNT_MAX = DIV_TIMEOUT + FIX_LAT + DIV_SETTLE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] FIX_LAT_C  = CNT_W'(FIX_LAT);
  localparam logic [CNT_W-1:0] SETTLE_C   = CNT_W'(DIV_SETTLE);
  localparam logic [CNT_W-1:0] TO_LAST_C  = CNT_W'(DIV_TIMEOUT - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt + CNT_W'(1);

  assign out_ready      = (state == ST_IDLE);
  assign out_pipe_stall = (state != ST_IDLE);
  assign out_fpu_start  = (state == ST_ISSUE);
  assign out_wb_valid   = (state == ST_RESULT);

  always_ff @(posedge in_Clk) begin
    if (in_Rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      out_fpu_rs1 <= '0;
      out_fpu_rs2 <= '0;
      out_fpu_op  <= '0;
      out_wb_rd   <= '0;
      out_wb_data <= '0;
      out_err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && !in_flush) begin
            out_fpu_rs1 <= in_rs1;
            out_fpu_rs2 <= in_rs2;
            out_fpu_op  <= in_FPU_Op;
            out_wb_rd   <= in_rd;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (in_flush) begin
            state <= ST_IDLE;
          end else if (out_fpu_op == OP_DIV) begin
            state <= ST_WAIT_DIV;
            cnt   <= '0;
          end else begin
            state <= ST_WAIT_FIX;
            cnt   <= CNT_W'(1);
          end
        end
        ST_WAIT_FIX: begin
          if (in_flush) begin
            state <= ST_IDLE;
          end else if (cnt == FIX_LAT_C) begin
            out_wb_data <= in_fpu_data;
            state       <= ST_RESULT;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_WAIT_DIV: begin
          // FP_Unit cannot abort a divide, so a flush must wait it out in DRAIN.
          // The counter keeps running so DRAIN shares the same timeout budget.
          if (in_flush) begin
            state <= ST_DRAIN;
            cnt   <= cnt_inc;
          end else if (cnt != '0 && !in_fpu_stall) begin
            // cnt==0 is the cycle right after start, where stall may not be up yet.
            state <= ST_SETTLE;
            cnt   <= '0;
          end else if (cnt >= TO_LAST_C) begin
            out_err <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_DRAIN: begin
          if (!in_fpu_stall) begin
            state <= ST_IDLE;
          end else if (cnt >= TO_LAST_C) begin
            out_err <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_SETTLE: begin
          // Sample on the DIV_SETTLE-th edge after stall was seen low.
          if (in_flush) begin
            state <= ST_IDLE;
          end else if (cnt_inc == SETTLE_C) begin
            out_wb_data <= in_fpu_data;
            state       <= ST_RESULT;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_RESULT: begin
          // Flush takes priority over a simultaneous writeback consume.
          if (in_flush || in_wb_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl; FP_Unit behaviour is scripted step by step.
// Inputs are driven 1 time unit after each rising edge and outputs are sampled at the same point.
// Data from the scripted FP_Unit is garbage except in the exact cycle it is meant to be sampled.
module tb_fpu_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [1:0]  op;
  logic [4:0]  rd;
  logic        flush;
  logic        ready;
  logic        pipe_stall;
  logic [31:0] fpu_rs1;
  logic [31:0] fpu_rs2;
  logic [1:0]  fpu_op;
  logic        fpu_start;
  logic [31:0] fpu_data;
  logic        fpu_stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic        err;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] JUNK = 32'hDEADBEEF;

  fpu_issue_ctrl #(.FIX_LAT(2), .DIV_SETTLE(2), .DIV_TIMEOUT(64)) dut (
    .in_Clk        (clk),
    .in_Rst        (rst),
    .in_valid      (valid),
    .in_rs1        (rs1),
    .in_rs2        (rs2),
    .in_FPU_Op     (op),
    .in_rd         (rd),
    .in_flush      (flush),
    .out_ready     (ready),
    .out_pipe_stall(pipe_stall),
    .out_fpu_rs1   (fpu_rs1),
    .out_fpu_rs2   (fpu_rs2),
    .out_fpu_op    (fpu_op),
    .out_fpu_start (fpu_start),
    .in_fpu_data   (fpu_data),
    .in_fpu_stall  (fpu_stall),
    .out_wb_valid  (wb_valid),
    .out_wb_rd     (wb_rd),
    .out_wb_data   (wb_data),
    .in_wb_ready   (wb_ready),
    .out_err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, {31'd0, ready}, 32'd1);
    chk({tag, "_stall"}, {31'd0, pipe_stall}, 32'd0);
    chk({tag, "_wbv"}, {31'd0, wb_valid}, 32'd0);
    chk({tag, "_start"}, {31'd0, fpu_start}, 32'd0);
  endtask

  // Fixed-latency op: accept, start pulse, data valid only 2 cycles after start, hold in RESULT.
  task automatic run_fix(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] d, input logic [31:0] res,
                         input int hold);
    valid = 1'b1; rs1 = a; rs2 = b; op = o; rd = d;
    wb_ready = (hold == 0);
    fpu_data = JUNK;
    chk({tag, "_pre_ready"}, {31'd0, ready}, 32'd1);
    tick();                       // accepted -> ISSUE
    valid = 1'b0; rs1 = JUNK; rs2 = JUNK; op = 2'b11; rd = 5'd31;
    chk({tag, "_start"}, {31'd0, fpu_start}, 32'd1);
    chk({tag, "_stall_issue"}, {31'd0, pipe_stall}, 32'd1);
    chk({tag, "_ready_issue"}, {31'd0, ready}, 32'd0);
    chk({tag, "_fpu_rs1"}, fpu_rs1, a);
    chk({tag, "_fpu_rs2"}, fpu_rs2, b);
    chk({tag, "_fpu_op"}, {30'd0, fpu_op}, {30'd0, o});
    tick();                       // WAIT_FIX, first cycle after start
    chk({tag, "_start_drop"}, {31'd0, fpu_start}, 32'd0);
    chk({tag, "_wbv_early"}, {31'd0, wb_valid}, 32'd0);
    tick();                       // second cycle after start: FP_Unit data valid now
    fpu_data = res;
    chk({tag, "_wbv_early2"}, {31'd0, wb_valid}, 32'd0);
    tick();                       // RESULT (FIX_LAT+1 edges after accept)
    fpu_data = JUNK;
    chk({tag, "_wbv"}, {31'd0, wb_valid}, 32'd1);
    chk({tag, "_wbdata"}, wb_data, res);
    chk({tag, "_wbrd"}, {27'd0, wb_rd}, {27'd0, d});
    chk({tag, "_stall_res"}, {31'd0, pipe_stall}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold_wbv"}, {31'd0, wb_valid}, 32'd1);
      chk({tag, "_hold_data"}, wb_data, res);
      chk({tag, "_hold_ready"}, {31'd0, ready}, 32'd0);
    end
    wb_ready = 1'b1;
    tick();
    check_idle({tag, "_done"});
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; rs1 = '0; rs2 = '0; op = '0; rd = '0; flush = 1'b0;
    fpu_data = JUNK; fpu_stall = 1'b0; wb_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_idle("reset");
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_wbdata", wb_data, 32'd0);
    chk("reset_fpu_rs1", fpu_rs1, 32'd0);

    // 1) ADD 1.0 + 1.0 = 2.0
    run_fix("add", 2'b00, 32'h3f800000, 32'h3f800000, 5'd5, 32'h40000000, 0);

    // 2) DIV 6.0 / 2.0 = 3.0; stall rises late, result sampled 2 edges after stall low
    valid = 1'b1; rs1 = 32'h40c00000; rs2 = 32'h40000000; op = 2'b11; rd = 5'd7;
    wb_ready = 1'b1;
    tick();                       // ISSUE
    valid = 1'b0; rs1 = JUNK; rs2 = JUNK;
    chk("div_start", {31'd0, fpu_start}, 32'd1);
    tick();                       // WAIT_DIV first cycle, stall not yet up
    tick();                       // must not have left WAIT_DIV on the early low stall
    fpu_stall = 1'b1;
    chk("div_skip_first", {31'd0, pipe_stall}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("div_busy_stall", {31'd0, pipe_stall}, 32'd1);
      chk("div_busy_rs1", fpu_rs1, 32'h40c00000);
      chk("div_busy_wbv", {31'd0, wb_valid}, 32'd0);
    end
    fpu_stall = 1'b0;
    tick();                       // stall seen low -> SETTLE
    chk("div_settle_wbv", {31'd0, wb_valid}, 32'd0);
    tick();
    fpu_data = 32'h40400000;
    chk("div_settle_wbv2", {31'd0, wb_valid}, 32'd0);
    tick();                       // sampled -> RESULT
    fpu_data = JUNK;
    chk("div_wbv", {31'd0, wb_valid}, 32'd1);
    chk("div_wbdata", wb_data, 32'h40400000);
    chk("div_wbrd", {27'd0, wb_rd}, 32'd7);
    chk("div_rs1_stable", fpu_rs1, 32'h40c00000);
    chk("div_rs2_stable", fpu_rs2, 32'h40000000);
    chk("div_op_stable", {30'd0, fpu_op}, 32'd3);
    tick();
    check_idle("div_done");

    // 3) MUL 2.0 * 3.0 = 6.0 with writeback backpressure for 5 cycles
    run_fix("mul", 2'b10, 32'h40000000, 32'h40400000, 5'd9, 32'h40c00000, 5);

    // Flush in IDLE drops the op presented that cycle
    valid = 1'b1; flush = 1'b1; rs1 = 32'h3f800000; op = 2'b00;
    tick();
    valid = 1'b0; flush = 1'b0;
    check_idle("idle_flush");

    // 4) DIV 1.0 / 0.0 flushed two cycles in -> DRAIN until FP_Unit done, no result
    valid = 1'b1; rs1 = 32'h3f800000; rs2 = 32'h00000000; op = 2'b11; rd = 5'd2;
    wb_ready = 1'b1;
    tick();                       // ISSUE
    valid = 1'b0;
    tick();                       // WAIT_DIV
    fpu_stall = 1'b1;
    tick();
    flush = 1'b1;
    tick();                       // -> DRAIN
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("drain_stall", {31'd0, pipe_stall}, 32'd1);
      chk("drain_ready", {31'd0, ready}, 32'd0);
      chk("drain_wbv", {31'd0, wb_valid}, 32'd0);
      tick();
    end
    fpu_stall = 1'b0;
    fpu_data = 32'h7f800000;
    tick();                       // FP_Unit done, result discarded
    fpu_data = JUNK;
    check_idle("drain_done");
    chk("drain_err", {31'd0, err}, 32'd0);
    run_fix("post_flush_add", 2'b00, 32'h40000000, 32'h40000000, 5'd3, 32'h40800000, 0);

    // 5) Reset while in WAIT_FIX
    valid = 1'b1; rs1 = 32'h3f800000; rs2 = 32'h40000000; op = 2'b01; rd = 5'd4;
    wb_ready = 1'b1;
    tick();                       // ISSUE
    valid = 1'b0;
    tick();                       // WAIT_FIX
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("mid_reset");
    chk("mid_reset_wbdata", wb_data, 32'd0);
    chk("mid_reset_rs1", fpu_rs1, 32'd0);
    chk("mid_reset_rd", {27'd0, wb_rd}, 32'd0);
    fpu_data = 32'hbf800000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_reset_no_wbv", {31'd0, wb_valid}, 32'd0);
    end
    fpu_data = JUNK;

    // 6) FP_Unit stuck busy -> timeout after 64 cycles in WAIT_DIV, sticky error
    fpu_stall = 1'b1;
    valid = 1'b1; rs1 = 32'h40000000; rs2 = 32'h3f800000; op = 2'b11; rd = 5'd1;
    tick();                       // accept, ISSUE
    valid = 1'b0;
    for (int i = 0; i < 62; i++) tick();
    chk("to_err_early", {31'd0, err}, 32'd0);
    chk("to_stall_early", {31'd0, pipe_stall}, 32'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("to_err", {31'd0, err}, 32'd1);
    check_idle("to_idle");
    fpu_stall = 1'b0;
    tick();
    chk("to_err_sticky", {31'd0, err}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("to_err_cleared", {31'd0, err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
